// File: rtl/tetris_pkg.sv
// ============================================================================
// Package     : tetris_pkg
// Description : Shared types and colour constants for the falling-block game
//               video path (playfield size, RGB struct, board bitmap type).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tetris_pkg;

  localparam int PF_W = 200;
  localparam int PF_H = 400;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t CYAN      = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
  localparam rgb_t YELLOW    = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_t GREY      = '{r: 8'h80, g: 8'h80, b: 8'h80};
  localparam rgb_t GRID_GREY = '{r: 8'h30, g: 8'h30, b: 8'h30};
  localparam rgb_t BLACK     = '{r: 8'h00, g: 8'h00, b: 8'h00};

  // Placed-cell bitmap, indexed [row][col] with row 0 at the playfield top.
  typedef logic [PF_H-1:0][PF_W-1:0] board_t;

  // Half-brightness version of a colour (each channel shifted right by one).
  function automatic rgb_t dim(input rgb_t c);
    rgb_t d;
    d.r = {1'b0, c.r[7:1]};
    d.g = {1'b0, c.g[7:1]};
    d.b = {1'b0, c.b[7:1]};
    return d;
  endfunction

endpackage : tetris_pkg

`default_nettype wire

// File: rtl/square_hit.sv
// ============================================================================
// Module      : square_hit
// Description : Combinational box test - is the draw pixel inside a square
//               of edge size_i whose top-left corner is (pos_x_i, pos_y_i)?
//               Upper bounds are formed 11 bits wide so squares near the
//               right/bottom edge of the 10-bit range never wrap to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module square_hit (
  input  logic [9:0] pos_x_i,
  input  logic [9:0] pos_y_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic [9:0] size_i,
  output logic       hit_o
);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_in_x;
  logic        w_in_y;

  assign w_x_end = {1'b0, pos_x_i} + {1'b0, size_i};
  assign w_y_end = {1'b0, pos_y_i} + {1'b0, size_i};

  // A zero size makes each interval empty, so no separate size check is needed.
  assign w_in_x = (draw_x_i >= pos_x_i) && ({1'b0, draw_x_i} < w_x_end);
  assign w_in_y = (draw_y_i >= pos_y_i) && ({1'b0, draw_y_i} < w_y_end);
  assign hit_o  = w_in_x && w_in_y;

endmodule : square_hit

`default_nettype wire

// File: rtl/tetris_color_mapper.sv
// ============================================================================
// Module      : tetris_color_mapper
// Description : Per-pixel colour generator. Decodes the current draw pixel
//               into square / placed-cell / border / background regions,
//               picks the colour by priority, optionally dims it while the
//               game is paused, and registers RGB plus a sticky per-frame
//               overlap flag (one clock latency).
//               Optional feature macro: PF_GRID_EN (draws a 20 px grid in
//               dark grey on empty playfield pixels).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tetris_color_mapper
  import tetris_pkg::*;
#(
  parameter int PF_X0  = 220,
  parameter int PF_Y0  = 40,
  parameter int BORDER = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallX2,
  input  logic [9:0] BallY2,
  input  logic [9:0] BallX3,
  input  logic [9:0] BallY3,
  input  logic [9:0] BallX4,
  input  logic [9:0] BallY4,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] Ball_size,
  input  logic       pause_enable,
  input  board_t     game,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       flag
);

  // Region bounds, all 11 bits wide so the grown border rectangle cannot wrap.
  localparam logic [10:0] c_pf_x_lo  = 11'(PF_X0);
  localparam logic [10:0] c_pf_x_hi  = 11'(PF_X0 + PF_W);
  localparam logic [10:0] c_pf_y_lo  = 11'(PF_Y0);
  localparam logic [10:0] c_pf_y_hi  = 11'(PF_Y0 + PF_H);
  localparam logic [10:0] c_brd_x_lo = 11'(PF_X0 - BORDER);
  localparam logic [10:0] c_brd_x_hi = 11'(PF_X0 + PF_W + BORDER);
  localparam logic [10:0] c_brd_y_lo = 11'(PF_Y0 - BORDER);
  localparam logic [10:0] c_brd_y_hi = 11'(PF_Y0 + PF_H + BORDER);

  logic [9:0]  w_bx [4];
  logic [9:0]  w_by [4];
  logic [3:0]  w_hit;
  logic        w_any_hit;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_in_pf;
  logic        w_in_brd_box;
  logic        w_border;
  logic [8:0]  w_row;
  logic [7:0]  w_col;
  logic        w_cell;
  logic        w_grid;
  logic        w_frame_start;
  rgb_t        w_color;

  rgb_t        rgb_d, rgb_q;
  logic        flag_d, flag_q;

  assign w_bx[0] = BallX;
  assign w_bx[1] = BallX2;
  assign w_bx[2] = BallX3;
  assign w_bx[3] = BallX4;
  assign w_by[0] = BallY;
  assign w_by[1] = BallY2;
  assign w_by[2] = BallY3;
  assign w_by[3] = BallY4;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_sq
      square_hit u_hit (
        .pos_x_i  (w_bx[k]),
        .pos_y_i  (w_by[k]),
        .draw_x_i (DrawX),
        .draw_y_i (DrawY),
        .size_i   (Ball_size),
        .hit_o    (w_hit[k])
      );
    end : g_sq
  endgenerate

  assign w_any_hit = |w_hit;

  assign w_dx = {1'b0, DrawX};
  assign w_dy = {1'b0, DrawY};

  assign w_in_pf      = (w_dx >= c_pf_x_lo) && (w_dx < c_pf_x_hi) &&
                        (w_dy >= c_pf_y_lo) && (w_dy < c_pf_y_hi);
  assign w_in_brd_box = (w_dx >= c_brd_x_lo) && (w_dx < c_brd_x_hi) &&
                        (w_dy >= c_brd_y_lo) && (w_dy < c_brd_y_hi);
  assign w_border     = w_in_brd_box && !w_in_pf;

  // Board index is forced to zero outside the playfield and the cell masked,
  // so the bitmap is never addressed out of range.
  assign w_row  = w_in_pf ? 9'(w_dy - c_pf_y_lo) : 9'd0;
  assign w_col  = w_in_pf ? 8'(w_dx - c_pf_x_lo) : 8'd0;
  assign w_cell = w_in_pf && game[w_row][w_col];

`ifdef PF_GRID_EN
  logic [7:0] w_gx;
  logic [8:0] w_gy;
  assign w_gx   = w_col;
  assign w_gy   = w_row;
  assign w_grid = w_in_pf && ((w_gx % 8'd20 == 8'd0) || (w_gy % 9'd20 == 9'd0));
`else
  assign w_grid = 1'b0;
`endif

  assign w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  // Colour priority mux, pause dimming, and sticky overlap flag next-state.
  always_comb begin
    w_color = BLACK;
    if (w_any_hit) begin
      w_color = CYAN;
    end else if (w_cell) begin
      w_color = YELLOW;
    end else if (w_border) begin
      w_color = GREY;
    end else if (w_grid) begin
      w_color = GRID_GREY;
    end

    rgb_d  = pause_enable ? dim(w_color) : w_color;

    // Set has priority over the frame-start clear; the flag freezes while paused.
    flag_d = flag_q;
    if (!pause_enable) begin
      if (w_any_hit && w_cell) begin
        flag_d = 1'b1;
      end else if (w_frame_start) begin
        flag_d = 1'b0;
      end
    end
  end

  // Single output register stage with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q  <= BLACK;
      flag_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      flag_q <= flag_d;
    end
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;
  assign flag  = flag_q;

endmodule : tetris_color_mapper

`default_nettype wire

// File: tb/tb_tetris_color_mapper.sv
// ============================================================================
// Module      : tb_tetris_color_mapper
// Description : Self-checking bench for tetris_color_mapper: directed steps
//               followed by randomized pixels, compared against a plain
//               arithmetic reference model of the colour rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tetris_color_mapper;
  import tetris_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] BallX, BallY, BallX2, BallY2, BallX3, BallY3, BallX4, BallY4;
  logic [9:0] DrawX, DrawY, Ball_size;
  logic       pause_enable;
  board_t     game;
  logic [7:0] Red, Green, Blue;
  logic       flag;

  int n_checks = 0;
  int n_fail   = 0;
  bit m_flag   = 1'b0;

  always #5 Clk = ~Clk;

  tetris_color_mapper dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .BallX        (BallX),
    .BallY        (BallY),
    .BallX2       (BallX2),
    .BallY2       (BallY2),
    .BallX3       (BallX3),
    .BallY3       (BallY3),
    .BallX4       (BallX4),
    .BallY4       (BallY4),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .Ball_size    (Ball_size),
    .pause_enable (pause_enable),
    .game         (game),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .flag         (flag)
  );

  // Reference: does any of the four squares cover the current pixel?
  function automatic bit ref_hit();
    int bx[4];
    int by[4];
    int dx = int'(DrawX);
    int dy = int'(DrawY);
    int sz = int'(Ball_size);
    bit h = 1'b0;
    bx = '{int'(BallX), int'(BallX2), int'(BallX3), int'(BallX4)};
    by = '{int'(BallY), int'(BallY2), int'(BallY3), int'(BallY4)};
    for (int k = 0; k < 4; k++)
      if (dx >= bx[k] && dx < bx[k] + sz && dy >= by[k] && dy < by[k] + sz) h = 1'b1;
    return h;
  endfunction

  function automatic bit ref_cell();
    int dx = int'(DrawX);
    int dy = int'(DrawY);
    if (dx >= 220 && dx < 420 && dy >= 40 && dy < 440) return game[dy - 40][dx - 220];
    return 1'b0;
  endfunction

  function automatic logic [23:0] ref_color();
    int dx = int'(DrawX);
    int dy = int'(DrawY);
    bit inpf   = (dx >= 220 && dx < 420 && dy >= 40 && dy < 440);
    bit border = (dx >= 216 && dx < 424 && dy >= 36 && dy < 444) && !inpf;
    bit grid   = 1'b0;
    logic [23:0] c;
    int r, g, b;
`ifdef PF_GRID_EN
    grid = inpf && (((dx - 220) % 20) == 0 || ((dy - 40) % 20) == 0);
`endif
    if (ref_hit())      c = 24'h00FFFF;
    else if (ref_cell()) c = 24'hFFFF00;
    else if (border)    c = 24'h808080;
    else if (grid)      c = 24'h303030;
    else                c = 24'h000000;
    if (pause_enable) begin
      r = int'(c[23:16]) / 2;
      g = int'(c[15:8]) / 2;
      b = int'(c[7:0]) / 2;
      c = {8'(r), 8'(g), 8'(b)};
    end
    return c;
  endfunction

  // One clock: update the model from the inputs present at the edge, then check.
  task automatic tick_check(input string tag);
    logic [23:0] exp_rgb;
    @(posedge Clk);
    if (Reset) begin
      exp_rgb = 24'h0;
      m_flag  = 1'b0;
    end else begin
      exp_rgb = ref_color();
      if (!pause_enable) begin
        if (ref_hit() && ref_cell()) m_flag = 1'b1;
        else if (DrawX == 0 && DrawY == 0) m_flag = 1'b0;
      end
    end
    #1;
    n_checks++;
    assert ({Red, Green, Blue} === exp_rgb) else begin
      n_fail++;
      $error("FAIL %s rgb: got %06h expected %06h", tag, {Red, Green, Blue}, exp_rgb);
    end
    n_checks++;
    assert (flag === m_flag) else begin
      n_fail++;
      $error("FAIL %s flag: got %0b expected %0b", tag, flag, m_flag);
    end
  endtask

  task automatic all_squares(input int x, input int y, input int sz);
    BallX  = 10'(x); BallY  = 10'(y);
    BallX2 = 10'(x); BallY2 = 10'(y);
    BallX3 = 10'(x); BallY3 = 10'(y);
    BallX4 = 10'(x); BallY4 = 10'(y);
    Ball_size = 10'(sz);
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  initial begin
    Reset = 1'b1;
    pause_enable = 1'b0;
    game = '0;
    all_squares(600, 0, 10);
    pix(5, 5);

    // Reset state.
    tick_check("reset");
    Reset = 1'b0;

    // Square hit and just past its right edge.
    all_squares(200, 220, 10);
    pix(205, 225); tick_check("sq_hit");
    pix(210, 225); tick_check("sq_edge_miss");
    pix(209, 229); tick_check("sq_corner_hit");

    // Occupied cell and border.
    game[0][0] = 1'b1;
    all_squares(600, 0, 10);
    pix(220, 40);  tick_check("cell");
    pix(218, 40);  tick_check("border");
    pix(215, 40);  tick_check("border_outside");
    pix(419, 439); tick_check("pf_corner_empty");
    pix(423, 443); tick_check("border_corner");

    // Overlap sets flag; flag sticks until frame start.
    all_squares(220, 40, 10);
    pix(220, 40);  tick_check("overlap");
    pix(300, 300); tick_check("flag_hold");
    pix(0, 0);     tick_check("frame_clear");
    pix(1, 0);     tick_check("flag_cleared");

    // Pause dimming; flag frozen on overlap pixel.
    pause_enable = 1'b1;
    all_squares(200, 220, 10);
    pix(205, 225); tick_check("pause_dim");
    all_squares(220, 40, 10);
    pix(220, 40);  tick_check("pause_overlap");
    pause_enable = 1'b0;
    pix(220, 40);  tick_check("overlap_again");
    pause_enable = 1'b1;
    pix(0, 0);     tick_check("pause_no_clear");
    pause_enable = 1'b0;

    // No 10-bit wrap of the square bound; size zero never hits.
    all_squares(1020, 0, 10);
    pix(3, 5);     tick_check("no_wrap");
    pix(1023, 5);  tick_check("high_edge_hit");
    all_squares(300, 300, 0);
    pix(300, 300); tick_check("size_zero");

    // Grid line pixel (dark grey only with the grid build).
    all_squares(600, 0, 10);
    pix(240, 100); tick_check("grid_pixel");

    // Randomized pixels over a busy region of the board.
    for (int i = 0; i < 400; i++) game[$urandom_range(0, 59)][$urandom_range(0, 59)] = 1'b1;
    for (int i = 0; i < 800; i++) begin
      BallX  = 10'($urandom_range(200, 290)); BallY  = 10'($urandom_range(30, 100));
      BallX2 = 10'($urandom_range(200, 290)); BallY2 = 10'($urandom_range(30, 100));
      BallX3 = 10'($urandom_range(200, 290)); BallY3 = 10'($urandom_range(30, 100));
      BallX4 = 10'($urandom_range(200, 290)); BallY4 = 10'($urandom_range(30, 100));
      Ball_size = 10'($urandom_range(0, 20));
      if ($urandom_range(0, 29) == 0) pix(0, 0);
      else pix(int'($urandom_range(190, 300)), int'($urandom_range(25, 110)));
      pause_enable = ($urandom_range(0, 5) == 0);
      Reset = ($urandom_range(0, 49) == 0);
      tick_check("random");
    end
    Reset = 1'b0;
    pause_enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule : tb_tetris_color_mapper

`default_nettype wire
